// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: status codes, access-length codes and FSM states shared by
// the memory controller and anything that decodes its status outputs.
package mem_ctrl_pkg;

  localparam int STAT_W = 2;

  // Status reported back to the IF and MEM stages
  typedef enum logic [STAT_W-1:0] {
    STAT_IDLE     = 2'd0,
    STAT_BUSY     = 2'd1,
    STAT_IHANDLED = 2'd2,
    STAT_DHANDLED = 2'd3
  } stat_t;

  // Access length codes on data_access_len; 2'b10 is treated as a word
  typedef enum logic [1:0] {
    LEN_B = 2'b00,
    LEN_H = 2'b01,
    LEN_W = 2'b11
  } len_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Number of RAM bytes touched by an access of the given length code
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: owns the byte-wide RAM port and serves word fetches from IF and
// byte/half/word loads and stores from MEM, one byte per cycle. Data traffic
// wins when both requests are present.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              inst_access_enable,
  input  logic [ADDR_W-1:0] inst_access_addr,
  output logic [STAT_W-1:0] inst_access_stat,
  output logic [ADDR_W-1:0] inst_handled_addr,
  output logic [DATA_W-1:0] inst_access_data,
  input  logic              data_access_enable,
  input  logic              data_access_wr,
  input  logic [1:0]        data_access_len,
  input  logic [ADDR_W-1:0] data_access_addr,
  input  logic [DATA_W-1:0] data_write_data,
  output logic [STAT_W-1:0] data_access_stat,
  output logic [DATA_W-1:0] data_read_data,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [2:0]        nbytes;
  logic [2:0]        k;
  logic              is_inst;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rbuf;
  logic [DATA_W-1:0] rbuf_merged;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] cur_addr;
  logic              io_blocked;
  logic              grant_io_blocked;
  logic              last_byte;

  assign cur_addr         = base + ADDR_W'(k);
  assign io_blocked       = (cur_addr[17:16] == IO_HI) && io_buffer_full;
  assign grant_io_blocked = (data_access_addr[17:16] == IO_HI) && io_buffer_full;
  assign last_byte        = (k == nbytes - 3'd1);

  // While stalled the strobe register holds; gating it keeps a pending byte
  // from being committed until the stall ends, so it is written exactly once
  assign mem_wr = mem_wr_q & rdy;

  // Merge the byte returned by the RAM into its lane of the read buffer
  always_comb begin
    // NOTE: assign a full default first so every path drives the signal and no latch is inferred
    rbuf_merged = rbuf;
    rbuf_merged[{k[1:0], 3'b000} +: 8] = mem_din;
  end

  // Request arbitration, byte sequencing and registered status/data outputs
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values
    if (rst) begin
      state             <= S_IDLE;
      base              <= '0;
      nbytes            <= 3'd0;
      k                 <= 3'd0;
      is_inst           <= 1'b0;
      wdata             <= '0;
      rbuf              <= '0;
      mem_wr_q          <= 1'b0;
      mem_a             <= '0;
      mem_dout          <= 8'h00;
      inst_access_stat  <= STAT_IDLE;
      data_access_stat  <= STAT_IDLE;
      inst_access_data  <= '0;
      data_read_data    <= '0;
      inst_handled_addr <= '0;
    end else if (rdy) begin
      case (state)
        S_IDLE: begin
          mem_wr_q <= 1'b0;
          if (data_access_enable) begin
            base             <= data_access_addr;
            nbytes           <= len_bytes(data_access_len);
            is_inst          <= 1'b0;
            wdata            <= data_write_data;
            rbuf             <= '0;
            mem_a            <= data_access_addr;
            k                <= 3'd0;
            data_access_stat <= STAT_BUSY;
            if (data_access_wr) begin
              state <= S_WRITE;
              // First byte goes out on the grant edge unless the UART is full
              if (!grant_io_blocked) begin
                mem_dout <= data_write_data[7:0];
                mem_wr_q <= 1'b1;
                k        <= 3'd1;
              end
            end else begin
              state <= S_READ;
            end
          end else if (inst_access_enable) begin
            base             <= inst_access_addr;
            nbytes           <= 3'd4;
            is_inst          <= 1'b1;
            rbuf             <= '0;
            mem_a            <= inst_access_addr;
            k                <= 3'd0;
            inst_access_stat <= STAT_BUSY;
            state            <= S_READ;
          end
        end

        S_READ: begin
          rbuf <= rbuf_merged;
          if (last_byte) begin
            state <= S_DONE;
            if (is_inst) begin
              inst_access_data  <= rbuf_merged;
              inst_handled_addr <= base;
              inst_access_stat  <= STAT_IHANDLED;
            end else begin
              data_read_data   <= rbuf_merged;
              data_access_stat <= STAT_DHANDLED;
            end
          end else begin
            mem_a <= base + ADDR_W'(k + 3'd1);
            k     <= k + 3'd1;
          end
        end

        S_WRITE: begin
          if (k == nbytes) begin
            mem_wr_q         <= 1'b0;
            data_access_stat <= STAT_DHANDLED;
            state            <= S_DONE;
          end else if (io_blocked) begin
            mem_wr_q <= 1'b0;
          end else begin
            mem_a    <= cur_addr;
            mem_dout <= wdata[{k[1:0], 3'b000} +: 8];
            mem_wr_q <= 1'b1;
            k        <= k + 3'd1;
          end
        end

        S_DONE: begin
          inst_access_stat <= STAT_IDLE;
          data_access_stat <= STAT_IDLE;
          state            <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: drives fetches, loads and stores against a byte RAM model and
// compares every cycle with a transaction-level reference of the controller.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        inst_access_enable;
  logic [31:0] inst_access_addr;
  logic [1:0]  inst_access_stat;
  logic [31:0] inst_handled_addr;
  logic [31:0] inst_access_data;
  logic        data_access_enable;
  logic        data_access_wr;
  logic [1:0]  data_access_len;
  logic [31:0] data_access_addr;
  logic [31:0] data_write_data;
  logic [1:0]  data_access_stat;
  logic [31:0] data_read_data;
  logic        io_buffer_full;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .inst_access_enable (inst_access_enable),
    .inst_access_addr   (inst_access_addr),
    .inst_access_stat   (inst_access_stat),
    .inst_handled_addr  (inst_handled_addr),
    .inst_access_data   (inst_access_data),
    .data_access_enable (data_access_enable),
    .data_access_wr     (data_access_wr),
    .data_access_len    (data_access_len),
    .data_access_addr   (data_access_addr),
    .data_write_data    (data_write_data),
    .data_access_stat   (data_access_stat),
    .data_read_data     (data_read_data),
    .io_buffer_full     (io_buffer_full),
    .mem_din            (mem_din),
    .mem_dout           (mem_dout),
    .mem_a              (mem_a),
    .mem_wr             (mem_wr)
  );

  // Physical RAM seen by the controller, and the bench's view of its contents
  logic [7:0] ram    [logic [31:0]];
  logic [7:0] shadow [logic [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] ad);
    return ram.exists(ad) ? ram[ad] : 8'h00;
  endfunction

  function automatic logic [7:0] sh_rd(input logic [31:0] ad);
    return shadow.exists(ad) ? shadow[ad] : 8'h00;
  endfunction

  task automatic preload(input logic [31:0] ad, input logic [7:0] b);
    ram[ad]    = b;
    shadow[ad] = b;
  endtask

  // RAM: commit the write strobe seen at the edge; read data follows address
  always @(posedge clk) if (mem_wr) ram[mem_a] = mem_dout;
  always @(negedge clk) mem_din = ram_rd(mem_a);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Expected outputs after one clock edge
  typedef struct {
    logic [1:0]  stat_i;
    logic [1:0]  stat_d;
    logic        wr;
    logic [31:0] a;
    logic [7:0]  dout;
    logic [31:0] idata;
    logic [31:0] haddr;
    logic [31:0] ddata;
  } exp_t;

  exp_t exp_q[$];

  // Outputs that hold their value between transactions
  logic [31:0] m_a     = 32'h0;
  logic [7:0]  m_dout  = 8'h0;
  logic [31:0] m_idata = 32'h0;
  logic [31:0] m_haddr = 32'h0;
  logic [31:0] m_ddata = 32'h0;

  // Compare process: checks every cycle for which an expectation is queued
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      check("inst_stat",   32'(inst_access_stat), 32'(x.stat_i));
      check("data_stat",   32'(data_access_stat), 32'(x.stat_d));
      check("mem_wr",      32'(mem_wr),           32'(x.wr));
      check("mem_a",       mem_a,                 x.a);
      check("mem_dout",    32'(mem_dout),         32'(x.dout));
      check("inst_data",   inst_access_data,      x.idata);
      check("handled_adr", inst_handled_addr,     x.haddr);
      check("read_data",   data_read_data,        x.ddata);
    end
  end

  // One transaction, started at a negedge with the controller idle. The model
  // counts productive (rdy-high) edges: grant on the first, byte traffic after,
  // one Handled cycle, then back to Idle. Returns at a negedge.
  task automatic run_txn(input bit inst, input bit wr, input logic [31:0] a,
                         input logic [1:0] lc, input logic [31:0] wd,
                         input int stall_at, input int stall_n,
                         input int block_n, input bit hold_ie);
    int   n, e, eff, c;
    bit   done_rep, fin, io, act, blk;
    exp_t x;
    logic [31:0] rd;
    n  = (lc == 2'd0) ? 1 : (lc == 2'd1) ? 2 : 4;
    io = (a[17:16] == 2'b11);
    e = 0; eff = -1; c = 0; done_rep = 0; fin = 0;
    x.stat_i = 2'd0;
    x.stat_d = 2'd0;
    while (!fin && e < 200) begin
      act = !(e >= stall_at && e < stall_at + stall_n);
      blk = (e < block_n);
      rdy = act;
      io_buffer_full = blk;
      if (inst) begin
        inst_access_enable = !done_rep;
        inst_access_addr   = a;
        data_access_enable = 1'b0;
      end else begin
        inst_access_enable = hold_ie;
        data_access_enable = !done_rep;
        data_access_wr     = wr;
        data_access_len    = lc;
        data_access_addr   = a;
        data_write_data    = wd;
      end
      x.wr = 1'b0;
      if (act) begin
        eff++;
        if (done_rep) begin
          x.stat_i = 2'd0;
          x.stat_d = 2'd0;
          fin = 1;
        end else if (inst || !wr) begin
          if (eff == 0) begin
            if (inst) x.stat_i = 2'd1; else x.stat_d = 2'd1;
            m_a = a;
          end else if (eff < n) begin
            m_a = a + 32'(eff);
          end else begin
            rd = 32'h0;
            for (int i = 0; i < n; i++) rd[8*i +: 8] = sh_rd(a + 32'(i));
            if (inst) begin
              x.stat_i = 2'd2; m_idata = rd; m_haddr = a;
            end else begin
              x.stat_d = 2'd3; m_ddata = rd;
            end
            done_rep = 1;
          end
        end else begin
          if (eff == 0) begin
            x.stat_d = 2'd1;
            m_a = a;
          end
          if (c == n) begin
            x.stat_d = 2'd3;
            done_rep = 1;
          end else if (!(io && blk)) begin
            m_a    = a + 32'(c);
            m_dout = wd[8*c +: 8];
            x.wr   = 1'b1;
            shadow[m_a] = m_dout;
            c++;
          end
        end
      end
      x.a = m_a; x.dout = m_dout; x.idata = m_idata; x.haddr = m_haddr; x.ddata = m_ddata;
      exp_q.push_back(x);
      @(negedge clk);
      e++;
    end
    rdy = 1'b1;
    io_buffer_full = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rl;
    int          kind;

    rst = 1'b1; rdy = 1'b1;
    inst_access_enable = 1'b0; inst_access_addr = 32'h0;
    data_access_enable = 1'b0; data_access_wr = 1'b0; data_access_len = 2'd0;
    data_access_addr = 32'h0; data_write_data = 32'h0; io_buffer_full = 1'b0;

    preload(32'h10, 8'h13); preload(32'h11, 8'h05); preload(32'h12, 8'h00); preload(32'h13, 8'h00);
    preload(32'h100, 8'h78); preload(32'h101, 8'h56); preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    preload(32'h20, 8'h93); preload(32'h21, 8'h00); preload(32'h22, 8'h10); preload(32'h23, 8'h00);
    preload(32'hFFFFFFFE, 8'hAA); preload(32'hFFFFFFFF, 8'hBB); preload(32'h0, 8'h11); preload(32'h1, 8'h22);

    repeat (3) @(negedge clk);
    check("rst_inst_stat", 32'(inst_access_stat), 32'd0);
    check("rst_data_stat", 32'(data_access_stat), 32'd0);
    check("rst_mem_wr",    32'(mem_wr),           32'd0);
    check("rst_mem_a",     mem_a,                 32'h0);
    check("rst_mem_dout",  32'(mem_dout),         32'h0);
    check("rst_idata",     inst_access_data,      32'h0);
    check("rst_ddata",     data_read_data,        32'h0);
    check("rst_haddr",     inst_handled_addr,     32'h0);
    rst = 1'b0;

    // Plain fetch
    run_txn(1, 0, 32'h10, 2'd3, 32'h0, 99, 0, 0, 0);
    check("fetch_data",  inst_access_data,  32'h00000513);
    check("fetch_haddr", inst_handled_addr, 32'h10);

    // Simultaneous requests: load first, fetch after
    inst_access_addr = 32'h20;
    run_txn(0, 0, 32'h100, 2'd3, 32'h0, 99, 0, 0, 1);
    check("arb_load", data_read_data, 32'h12345678);
    run_txn(1, 0, 32'h20, 2'd3, 32'h0, 99, 0, 0, 0);
    check("arb_fetch", inst_access_data, 32'h00100093);

    // Half store and word readback
    run_txn(0, 1, 32'h200, 2'd1, 32'h0000BEEF, 99, 0, 0, 0);
    run_txn(0, 0, 32'h200, 2'd3, 32'h0, 99, 0, 0, 0);
    check("half_rdback", data_read_data, 32'h0000BEEF);

    // IO store held off by a full UART buffer
    run_txn(0, 1, 32'h00030000, 2'd0, 32'h41, 99, 0, 3, 0);
    check("io_byte", 32'(ram_rd(32'h00030000)), 32'h41);

    // Reset in the middle of a fetch
    rdy = 1'b1; io_buffer_full = 1'b0; data_access_enable = 1'b0;
    inst_access_addr = 32'h40; inst_access_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_istat", 32'(inst_access_stat), 32'd0);
    check("mid_rst_dstat", 32'(data_access_stat), 32'd0);
    check("mid_rst_wr",    32'(mem_wr),           32'd0);
    check("mid_rst_a",     mem_a,                 32'h0);
    check("mid_rst_idata", inst_access_data,      32'h0);
    @(negedge clk);
    rst = 1'b0; inst_access_enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no_ihandled", 32'(inst_access_stat), 32'd0);
    end
    @(negedge clk);
    m_a = 32'h0; m_dout = 8'h0; m_idata = 32'h0; m_haddr = 32'h0; m_ddata = 32'h0;
    run_txn(1, 0, 32'h10, 2'd3, 32'h0, 99, 0, 0, 0);
    check("post_rst_fetch", inst_access_data, 32'h00000513);

    // rdy low for two cycles in the middle of a read
    run_txn(1, 0, 32'h10, 2'd3, 32'h0, 2, 2, 0, 0);
    check("stall_fetch", inst_access_data, 32'h00000513);

    // Address wrap and the illegal length code
    run_txn(0, 0, 32'hFFFFFFFE, 2'd3, 32'h0, 99, 0, 0, 0);
    check("wrap_load", data_read_data, 32'h2211BBAA);
    run_txn(0, 0, 32'h100, 2'd2, 32'h0, 99, 0, 0, 0);
    check("len10_word", data_read_data, 32'h12345678);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) ra = 32'h00030000 + 32'($urandom_range(0, 15));
      else                           ra = 32'h00000400 + 32'($urandom_range(0, 31));
      rl = 2'($urandom_range(0, 3));
      if (kind == 0)
        run_txn(1, 0, ra & 32'hFFFFFFFC, 2'd3, 32'h0, int'($urandom_range(0, 6)),
                int'($urandom_range(0, 2)), 0, 0);
      else
        run_txn(0, kind == 2, ra, rl, $urandom, int'($urandom_range(0, 6)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder side of the instruction-fetch interface: accepts word fetch requests from the IF stage and returns a 32-bit instruction with an IHandled pulse.
- Also serves byte/half/word load and store requests from the MEM stage.
- Owns the single byte-wide synchronous RAM port and sequences multi-byte accesses one byte per cycle.
- Arbitrates between data and instruction traffic, with data winning.

Parameters:
- ADDR_W, 32, RAM address width (`RAMAddrLen).
- DATA_W, 32, instruction/data word width (`InstLen).
- IO_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes all state
- inst_access_enable  in  1  IF fetch request (level; held until IHandled)
- inst_access_addr  in  ADDR_W  fetch byte address, word aligned
- inst_access_stat  out  `MCtrlStatLen  fetch status: Idle/Busy/IHandled
- inst_handled_addr  out  ADDR_W  address of the fetch being reported
- inst_access_data  out  DATA_W  fetched instruction, little-endian assembled
- data_access_enable  in  1  MEM request (level)
- data_access_wr  in  1  1 = store, 0 = load
- data_access_len  in  2  0 = byte, 1 = half, 3 = word
- data_access_addr  in  ADDR_W  data byte address
- data_write_data  in  DATA_W  store data, low bytes used
- data_access_stat  out  `MCtrlStatLen  data status: Idle/Busy/DHandled
- data_read_data  out  DATA_W  load result, zero-extended raw bytes
- io_buffer_full  in  1  UART buffer full; blocks IO writes
- mem_din  in  8  RAM read byte, valid the cycle after its address
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  RAM write strobe

Behaviour:
- Reset is sampled on the clock edge. Reset outputs:
  - both stats = Idle
  - mem_wr = 0, mem_a = 0, mem_dout = 0
  - inst_access_data = 0, data_read_data = 0, inst_handled_addr = 0
  - FSM = IDLE
- Reset mid-transaction abandons the transaction; no Handled pulse is issued.
- rdy = 0: registers hold, and mem_wr is forced to 0 combinationally.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE, at an edge with any request enabled:
  - Latch address, length (fetch = 4 bytes), kind and write data; clear byte counter k.
  - Requester stat = Busy. If both requests are enabled, data is granted and IF stays Idle.
- READ, N bytes starting at A:
  - The grant edge E0 drives mem_a = A.
  - Edge Ei (i = 1..N-1) drives mem_a = A+i.
  - Edge E(i+1) captures mem_din into byte lane i.
  - Edge EN captures the last byte, sets Handled, and moves to DONE.
  - Latency: fetch Handled is visible in the cycle after E4.
- WRITE, N bytes:
  - Edge E(i) drives mem_a = A+i, mem_dout = byte i, mem_wr = 1, for i = 0..N-1.
  - Edge EN sets mem_wr = 0 and DHandled, and moves to DONE.
  - If addr[17:16] == IO_HI and io_buffer_full = 1, the next byte is not issued (mem_wr = 0) and the counter holds until io_buffer_full = 0.
- DONE:
  - Stat = IHandled/DHandled for exactly one cycle.
  - Next edge: stat = Idle, FSM = IDLE. A new grant happens no earlier than that IDLE edge.
- inst_handled_addr = latched fetch address, held from the DONE cycle until the next fetch completes. If IF's request address changed mid-fetch, the latched address is still completed and reported; IF discards it by address compare.
- inst_access_data and data_read_data hold their value after Handled until overwritten.
- Unused upper bytes of data_read_data are 0.
- Address arithmetic wraps modulo 2^ADDR_W.
- Lengths 2'b10 are illegal; treat as word.

Decomposition:
- Add to defines.v:
  - `MCtrlStatLen = 2
  - Stat codes: `MIdle = 0, `MBusy = 1, `IHandled = 2, `DHandled = 3
  - Length codes: `LenB, `LenH, `LenW
  - FSM state encodings
- No sub-module: byte counter and lane assembly stay inline.

Test Plan:
- Fetch at 0x00000010, RAM bytes 13,05,00,00 -> mem_a = 0x10..0x13 on consecutive cycles; IHandled pulses one cycle after E4 with data 0x00000513 and handled_addr 0x10; IF stat back to Idle on the next cycle.
- Simultaneous fetch 0x20 and load word 0x100 -> data served first (DHandled), fetch stays Idle, then fetch starts at IDLE and completes.
- Store half 0xBEEF to 0x200 -> mem_wr = 1 for exactly 2 cycles: (0x200, EF), (0x201, BE); DHandled follows; RAM word at 0x200 reads back 0x0000BEEF.
- Store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those cycles, one write occurs after release, then DHandled.
- Reset asserted at E2 of a fetch -> stats Idle, mem_wr = 0, no IHandled pulse; a fresh fetch afterwards completes normally.
- rdy low for 2 cycles mid-READ -> mem_a and counter frozen; same final data, latency extended by 2.
